// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared types and transition tables for the quadrature decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    typedef enum logic [1:0] {
        ENC_X1 = 2'd0,
        ENC_X2 = 2'd1,
        ENC_X4 = 2'd2
    } enc_mode_t;

    typedef enum logic [0:0] {
        CH_INIT = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Bit {prev_ab, cur_ab} is set for a forward / reverse single-bit step,
    // where ab = {A, B} and forward is 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [15:0] C_FWD_LUT = 16'h2814;
    localparam logic [15:0] C_REV_LUT = 16'h4182;

endpackage
`default_nettype wire

// File: rtl/enc_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : enc_input_filter
// Description : One encoder pin: multi-flop synchroniser plus run-length filter.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_valid
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] C_FILT_LEN = CNT_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_valid;

    logic             w_sample;
    logic             w_live;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_streak;

    always_comb begin
        w_sample  = r_sync[SYNC_STAGES-1];
        w_live    = r_fill[SYNC_STAGES-1];
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_streak  = (w_sample == r_level) ? w_cnt_inc : CNT_W'(1);
    end

    // r_fill marks when the synchroniser holds real pin data rather than
    // reset zeros, so an idle-high pin is never first seen as low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (w_live) begin
                if (!r_valid) begin
                    // Acquisition: first run of FILT_LEN identical samples.
                    r_level <= w_sample;
                    if (w_streak == C_FILT_LEN) begin
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_streak;
                    end
                end else if (w_sample != r_level) begin
                    if (w_cnt_inc == C_FILT_LEN) begin
                        r_level <= w_sample;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_decoder
// Description : Multi-channel quadrature decoder with 1x/2x/4x modes, position
//               counters and sticky illegal-transition flags.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_decoder
    import enc_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int POS_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_CH-1:0]       i_a,
    input  logic [N_CH-1:0]       i_b,
    input  logic [N_CH-1:0]       i_polarity,
    input  logic [1:0]            i_mode,
    input  logic [N_CH-1:0]       i_clear,
    input  logic [N_CH-1:0]       i_err_clr,
    output logic [N_CH-1:0]       o_step,
    output logic [N_CH-1:0]       o_dir,
    output logic [N_CH*POS_W-1:0] o_pos,
    output logic [N_CH-1:0]       o_err
);

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            logic             w_a_lvl;
            logic             w_b_lvl;
            logic             w_a_vld;
            logic             w_b_vld;
            logic [1:0]       r_cur;
            logic             r_cur_vld;
            logic [1:0]       r_prev;
            ch_state_t        r_state;
            ch_state_t        w_state_nxt;
            logic             w_load_prev;
            logic             w_count;
            logic             w_set_err;
            logic [3:0]       w_idx;
            logic             w_fwd;
            logic             w_rev;
            logic             w_gate;
            logic             w_dir;
            logic             r_step;
            logic             r_dir;
            logic             r_err;
            logic [POS_W-1:0] r_pos;

            enc_input_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_flt_a (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_d     (i_a[k]),
                .o_level (w_a_lvl),
                .o_valid (w_a_vld)
            );

            enc_input_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN)
            ) u_flt_b (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_d     (i_b[k]),
                .o_level (w_b_lvl),
                .o_valid (w_b_vld)
            );

            always_comb begin
                w_idx = {r_prev, r_cur};
                w_fwd = C_FWD_LUT[w_idx];
                w_rev = C_REV_LUT[w_idx];
                w_dir = w_fwd ^ i_polarity[k];
                // X1 counts A rising going forward and A falling going back.
                if (i_mode == ENC_X1) begin
                    w_gate = (w_fwd & ~r_prev[1] & r_cur[1]) |
                             (w_rev & r_prev[1] & ~r_cur[1]);
                end else if (i_mode == ENC_X2) begin
                    w_gate = (w_fwd | w_rev) & (r_prev[1] ^ r_cur[1]);
                end else begin
                    w_gate = w_fwd | w_rev;
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_load_prev = 1'b0;
                w_count     = 1'b0;
                w_set_err   = 1'b0;
                case (r_state)
                    CH_INIT: begin
                        if (r_cur_vld) begin
                            w_load_prev = 1'b1;
                            w_state_nxt = CH_RUN;
                        end
                    end
                    CH_RUN: begin
                        w_load_prev = 1'b1;
                        w_count     = w_gate;
                        w_set_err   = ((r_prev ^ r_cur) == 2'b11);
                    end
                    default: w_state_nxt = CH_INIT;
                endcase
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_state <= CH_INIT;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cur     <= 2'b00;
                    r_cur_vld <= 1'b0;
                    r_prev    <= 2'b00;
                    r_step    <= 1'b0;
                    r_dir     <= 1'b0;
                    r_err     <= 1'b0;
                    r_pos     <= '0;
                end else begin
                    r_cur     <= {w_a_lvl, w_b_lvl};
                    r_cur_vld <= w_a_vld & w_b_vld;
                    if (w_load_prev) begin
                        r_prev <= r_cur;
                    end
                    r_step <= w_count;
                    r_dir  <= w_count & w_dir;
                    if (i_clear[k]) begin
                        r_pos <= '0;
                    end else if (w_count) begin
                        r_pos <= r_pos + {{(POS_W-1){~w_dir}}, 1'b1};
                    end
                    if (w_set_err) begin
                        r_err <= 1'b1;
                    end else if (i_err_clr[k]) begin
                        r_err <= 1'b0;
                    end
                end
            end

            assign o_step[k]                 = r_step;
            assign o_dir[k]                  = r_dir;
            assign o_err[k]                  = r_err;
            assign o_pos[k*POS_W +: POS_W]   = r_pos;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_decoder
// Description : Self-checking bench for quad_encoder_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  a = 2'b00, b = 2'b00, pol = 2'b00, mode = 2'd2;
    logic [1:0]  clr = 2'b00, eclr = 2'b00;
    logic [1:0]  step, dir, err;
    logic [31:0] pos;

    logic        a2 = 1'b0, b2 = 1'b0, clr2 = 1'b0;
    logic        step2, dir2, err2;
    logic [15:0] pos2;

    int n_checks = 0;
    int n_errors = 0;
    int up_cnt[2] = '{0, 0};
    int dn_cnt[2] = '{0, 0};
    int dir_viol  = 0;

    int         mpos[2];
    bit         merr[2];
    logic [1:0] mab[2];

    quad_encoder_decoder #(.N_CH(2), .POS_W(16), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_polarity(pol), .i_mode(mode),
        .i_clear(clr), .i_err_clr(eclr), .o_step(step), .o_dir(dir), .o_pos(pos), .o_err(err)
    );

    quad_encoder_decoder #(.N_CH(1), .POS_W(16), .SYNC_STAGES(2), .FILT_LEN(1)) dut_fast (
        .i_clk(clk), .i_rst(rst), .i_a(a2), .i_b(b2), .i_polarity(1'b0), .i_mode(2'd2),
        .i_clear(clr2), .i_err_clr(1'b0), .o_step(step2), .o_dir(dir2), .o_pos(pos2), .o_err(err2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (step[k]) begin
                if (dir[k]) up_cnt[k] = up_cnt[k] + 1;
                else        dn_cnt[k] = dn_cnt[k] + 1;
            end else if (dir[k]) begin
                dir_viol = dir_viol + 1;
            end
        end
    end

    // Position of an AB code around the forward cycle 00,10,11,01.
    function automatic int seq_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] seq_ab(input int i);
        case (((i % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] next_ab(input logic [1:0] ab, input bit fwd);
        return seq_ab(seq_idx(ab) + (fwd ? 1 : 3));
    endfunction

    function automatic logic [15:0] pos_of(input int ch);
        return pos[ch*16 +: 16];
    endfunction

    function automatic int steps_of(input int ch);
        return up_cnt[ch] + dn_cnt[ch];
    endfunction

    // Reference model: update expected count/error for a new AB level, then drive it.
    task automatic model_apply(input int ch, input logic [1:0] nab);
        int d;
        bit fwd;
        bit counted;
        d       = (seq_idx(nab) - seq_idx(mab[ch]) + 4) % 4;
        fwd     = (d == 1);
        counted = 1'b0;
        if (d == 2) merr[ch] = 1'b1;
        if (d == 1 || d == 3) begin
            if (mode == 2'd0)      counted = fwd ? (!mab[ch][1] && nab[1]) : (mab[ch][1] && !nab[1]);
            else if (mode == 2'd1) counted = (mab[ch][1] != nab[1]);
            else                   counted = 1'b1;
            if (counted) mpos[ch] = (mpos[ch] + ((fwd ^ pol[ch]) ? 1 : -1)) & 16'hFFFF;
        end
        mab[ch] = nab;
        a[ch]   = nab[1];
        b[ch]   = nab[0];
    endtask

    task automatic move_hold(input int ch, input logic [1:0] nab, input int n);
        @(negedge clk);
        model_apply(ch, nab);
        repeat (n) @(posedge clk);
    endtask

    task automatic move_timed(input int ch, input logic [1:0] nab, output int lat, output int np, output logic d);
        @(negedge clk);
        model_apply(ch, nab);
        np = 0; lat = -1; d = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (step[ch]) begin
                np++;
                if (np == 1) begin lat = i; d = dir[ch]; end
            end
        end
    endtask

    task automatic pulse_clr(input logic [1:0] m);
        @(negedge clk) clr = m;
        @(negedge clk) clr = 2'b00;
        for (int k = 0; k < 2; k++) if (m[k]) mpos[k] = 0;
    endtask

    task automatic pulse_eclr(input logic [1:0] m);
        @(negedge clk) eclr = m;
        @(negedge clk) eclr = 2'b00;
        for (int k = 0; k < 2; k++) if (m[k]) merr[k] = 1'b0;
    endtask

    task automatic test_reset;
        int s0;
        a = 2'b11; b = 2'b11; mode = 2'd2; pol = 2'b00;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (pos !== 32'd0 || step !== 2'b00 || dir !== 2'b00)
            $display("FAIL reset_outputs: pos=%h step=%b dir=%b expected 0", pos, step, dir);
        n_checks++;
        if (err !== 2'b00) $display("FAIL reset_err: got %b expected 00", err);
        if (err !== 2'b00) n_errors++;
        if (pos !== 32'd0 || step !== 2'b00 || dir !== 2'b00) n_errors++;
        @(negedge clk) rst = 1'b0;
        s0 = steps_of(0) + steps_of(1);
        for (int k = 0; k < 2; k++) begin mab[k] = 2'b11; mpos[k] = 0; merr[k] = 1'b0; end
        repeat (12) @(posedge clk); #1;
        n_checks++;
        if (err !== 2'b00) begin n_errors++; $display("FAIL startup_err: got %b expected 00", err); end
        n_checks++;
        if (steps_of(0) + steps_of(1) !== s0) begin
            n_errors++; $display("FAIL startup_steps: got %0d pulses expected 0", steps_of(0) + steps_of(1) - s0);
        end
        n_checks++;
        if (pos !== 32'd0) begin n_errors++; $display("FAIL startup_pos: got %h expected 0", pos); end
    endtask

    task automatic test_x4_fwd;
        int lat, np;
        logic d;
        mode = 2'd2; pol = 2'b00;
        for (int i = 0; i < 8; i++) begin
            move_timed(0, next_ab(mab[0], 1'b1), lat, np, d);
            n_checks++;
            if (np !== 1 || lat !== 6 || d !== 1'b1) begin
                n_errors++;
                $display("FAIL x4_fwd_edge%0d: pulses=%0d latency=%0d dir=%b expected 1/6/1", i, np, lat, d);
            end
        end
        n_checks++;
        if (pos_of(0) !== 16'd8) begin n_errors++; $display("FAIL x4_fwd_pos: got %h expected 0008", pos_of(0)); end
        for (int i = 0; i < 8; i++) begin
            move_timed(0, next_ab(mab[0], 1'b0), lat, np, d);
            n_checks++;
            if (np !== 1 || lat !== 6 || d !== 1'b0) begin
                n_errors++;
                $display("FAIL x4_rev_edge%0d: pulses=%0d latency=%0d dir=%b expected 1/6/0", i, np, lat, d);
            end
        end
        n_checks++;
        if (pos_of(0) !== 16'd0) begin n_errors++; $display("FAIL x4_rev_pos: got %h expected 0000", pos_of(0)); end
    endtask

    task automatic test_modes;
        logic [15:0] exp_pos [3];
        logic [1:0]  mode_v  [3];
        logic [1:0]  pol_v   [3];
        exp_pos = '{16'd4, 16'd2, 16'hFFF8};
        mode_v  = '{2'd1, 2'd0, 2'd2};
        pol_v   = '{2'b00, 2'b00, 2'b01};
        for (int m = 0; m < 3; m++) begin
            pulse_clr(2'b01);
            mode = mode_v[m]; pol = pol_v[m];
            for (int i = 0; i < 8; i++) move_hold(0, next_ab(mab[0], 1'b1), 20);
            #1;
            n_checks++;
            if (pos_of(0) !== exp_pos[m]) begin
                n_errors++; $display("FAIL mode%0d_pos: got %h expected %h", m, pos_of(0), exp_pos[m]);
            end
        end
        pol = 2'b00; mode = 2'd2;
        pulse_clr(2'b01);
    endtask

    task automatic test_glitch_err;
        int s0;
        logic [15:0] p0;
        mode = 2'd2; pol = 2'b00;
        p0 = pos_of(0); s0 = steps_of(0);
        @(negedge clk) a[0] = ~a[0];
        repeat (2) @(negedge clk);
        a[0] = ~a[0];
        repeat (20) @(posedge clk); #1;
        n_checks++;
        if (steps_of(0) !== s0 || pos_of(0) !== p0) begin
            n_errors++; $display("FAIL glitch: pulses=%0d pos=%h expected 0 pulses pos=%h", steps_of(0) - s0, pos_of(0), p0);
        end
        move_hold(0, next_ab(mab[0], 1'b1), 15);
        move_hold(0, next_ab(mab[0], 1'b1), 15);
        s0 = steps_of(0);
        move_hold(0, ~mab[0], 15); #1;
        n_checks++;
        if (err !== 2'b01 || steps_of(0) !== s0 || pos_of(0) !== mpos[0][15:0]) begin
            n_errors++;
            $display("FAIL illegal_jump: err=%b pulses=%0d pos=%h expected err=01 0 pulses pos=%h",
                     err, steps_of(0) - s0, pos_of(0), mpos[0][15:0]);
        end
        pulse_eclr(2'b01); #1;
        n_checks++;
        if (err[0] !== 1'b0) begin n_errors++; $display("FAIL err_clear: got %b expected 0", err[0]); end
        // Illegal jump decoded in the same cycle as an err_clr pulse.
        @(negedge clk) model_apply(0, ~mab[0]);
        repeat (6) @(posedge clk);
        @(negedge clk) eclr = 2'b01;
        @(posedge clk); #1;
        eclr = 2'b00;
        n_checks++;
        if (err[0] !== 1'b1) begin n_errors++; $display("FAIL err_set_wins: got %b expected 1", err[0]); end
        repeat (10) @(posedge clk);
        pulse_eclr(2'b01);
    endtask

    task automatic test_clear_coincident;
        mode = 2'd2; pol = 2'b00;
        @(negedge clk) model_apply(0, next_ab(mab[0], 1'b1));
        repeat (6) @(posedge clk);
        @(negedge clk) clr = 2'b01;
        @(posedge clk); #1;
        n_checks++;
        if (step[0] !== 1'b1 || pos_of(0) !== 16'd0) begin
            n_errors++; $display("FAIL clear_with_step: step=%b pos=%h expected 1/0000", step[0], pos_of(0));
        end
        @(negedge clk) clr = 2'b00;
        mpos[0] = 0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_wrap;
        int idx;
        idx = 0;
        for (int i = 0; i < 32767; i++) begin
            @(negedge clk); idx++; {a2, b2} = seq_ab(idx);
        end
        repeat (10) @(posedge clk); #1;
        n_checks++;
        if (pos2 !== 16'h7FFF) begin n_errors++; $display("FAIL wrap_preload: got %h expected 7fff", pos2); end
        @(negedge clk); idx++; {a2, b2} = seq_ab(idx);
        repeat (10) @(posedge clk); #1;
        n_checks++;
        if (pos2 !== 16'h8000) begin n_errors++; $display("FAIL wrap_pos_max: got %h expected 8000", pos2); end
        @(negedge clk) clr2 = 1'b1;
        @(negedge clk) clr2 = 1'b0;
        idx--; {a2, b2} = seq_ab(idx);
        repeat (10) @(posedge clk); #1;
        n_checks++;
        if (pos2 !== 16'hFFFF || err2 !== 1'b0 || dir2 !== 1'b0) begin
            n_errors++; $display("FAIL wrap_below_zero: pos=%h err=%b expected ffff/0", pos2, err2);
        end
    endtask

    task automatic test_dual;
        int s0;
        pulse_clr(2'b11);
        mode = 2'd2; pol = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model_apply(0, next_ab(mab[0], 1'b1));
            model_apply(1, next_ab(mab[1], 1'b0));
            repeat (20) @(posedge clk);
        end
        #1;
        n_checks++;
        if (pos_of(0) !== 16'd4 || pos_of(1) !== 16'hFFFC) begin
            n_errors++; $display("FAIL dual_counts: ch0=%h ch1=%h expected 0004/fffc", pos_of(0), pos_of(1));
        end
        move_hold(1, ~mab[1], 15); #1;
        n_checks++;
        if (err !== 2'b10) begin n_errors++; $display("FAIL dual_err_isolation: got %b expected 10", err); end
        @(negedge clk);
        model_apply(0, next_ab(mab[0], 1'b1));
        model_apply(1, next_ab(mab[1], 1'b0));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pos !== 32'd0 || step !== 2'b00 || dir !== 2'b00 || err !== 2'b00) begin
            n_errors++; $display("FAIL async_reset: pos=%h step=%b dir=%b err=%b expected all 0", pos, step, dir, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin mpos[k] = 0; merr[k] = 1'b0; end
        s0 = steps_of(0) + steps_of(1);
        repeat (20) @(posedge clk); #1;
        n_checks++;
        if (err !== 2'b00 || pos !== 32'd0 || steps_of(0) + steps_of(1) !== s0) begin
            n_errors++; $display("FAIL reinit_after_reset: err=%b pos=%h pulses=%0d expected 00/0/0",
                                 err, pos, steps_of(0) + steps_of(1) - s0);
        end
    endtask

    task automatic test_random;
        int r;
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            mode = 2'($urandom_range(0, 3));
            pol  = 2'($urandom_range(0, 3));
            for (int ch = 0; ch < 2; ch++) begin
                r = $urandom_range(0, 9);
                if (r < 4)       model_apply(ch, next_ab(mab[ch], 1'b1));
                else if (r < 8)  model_apply(ch, next_ab(mab[ch], 1'b0));
                else if (r == 8) model_apply(ch, ~mab[ch]);
            end
            repeat ($urandom_range(10, 16)) @(posedge clk);
            #1;
            for (int ch = 0; ch < 2; ch++) begin
                n_checks++;
                if (pos_of(ch) !== mpos[ch][15:0]) begin
                    n_errors++; $display("FAIL rand_pos it%0d ch%0d: got %h expected %h", it, ch, pos_of(ch), mpos[ch][15:0]);
                end
                n_checks++;
                if (err[ch] !== merr[ch]) begin
                    n_errors++; $display("FAIL rand_err it%0d ch%0d: got %b expected %b", it, ch, err[ch], merr[ch]);
                end
            end
            if (it % 8 == 7) pulse_eclr(2'b11);
        end
    endtask

    initial begin
        test_reset();
        test_x4_fwd();
        test_modes();
        test_glitch_err();
        test_clear_coincident();
        test_wrap();
        test_dual();
        test_random();
        n_checks++;
        if (dir_viol !== 0) begin n_errors++; $display("FAIL dir_without_step: got %0d cycles expected 0", dir_viol); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quad_encoder_decoder.md
Name: quad_encoder_decoder

Overview:
Multi-channel quadrature encoder front end for the motor subsystem. Per channel it synchronises and deglitches the raw A/B pins, then decodes the Gray-code sequence in a selectable 1x/2x/4x mode. It emits single-cycle step/direction pulses, keeps a wrapping signed position count and flags illegal transitions. It sits between the encoder pads and the speed/position control loops.

Parameters:
N_CH, 2, number of independent encoder channels (>=1)
POS_W, 16, width of each position counter (>=2)
SYNC_STAGES, 2, flip-flop synchroniser depth on A and B (>=2)
FILT_LEN, 3, consecutive identical synchronised samples needed to accept a new level (>=1; 1 = no filtering)

Ports:
i_clk  in  1  master clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_a  in  N_CH  encoder A inputs, asynchronous
i_b  in  N_CH  encoder B inputs, asynchronous
i_polarity  in  N_CH  per-channel direction inversion
i_mode  in  2  decode mode (enc_mode_t): 0=X1, 1=X2, 2=X4, 3=reserved (treated as X4)
i_clear  in  N_CH  synchronous zero of the position counter
i_err_clr  in  N_CH  clears the sticky error flag
o_step  out  N_CH  single-cycle pulse per counted edge
o_dir  out  N_CH  direction of the current step (1 = count up); valid when o_step=1, else 0
o_pos  out  N_CH*POS_W  packed position counters, channel k at [k*POS_W +: POS_W], two's complement
o_err  out  N_CH  sticky illegal-transition flag

Behaviour:
- Reset (i_rst=1, async): all synchroniser and filter flops, filter counters, o_step, o_dir, o_pos, o_err = 0; every channel enters INIT.
- Filter, per bit: sample at synchroniser output. If the sample differs from the accepted level, increment the counter. Otherwise clear it. When the counter would reach FILT_LEN, load the sample as the accepted level and clear the counter.
- Per-channel FSM:
  - INIT: wait for the first accepted sample of both bits after reset. Load prev_ab = current accepted AB. Go to RUN. No step and no error is emitted on this load, so a channel idling at 11 does not flag at startup.
  - RUN: each cycle compare accepted AB (cur) with prev_ab, then set prev_ab <= cur.
- Decode, with fwd sequence 00->10->11->01->00 (A leads B):
  - cur==prev: nothing.
  - Exactly one bit changed: raw_dir = 1 if the transition is in the fwd sequence, else 0.
  - Both bits changed: o_err<=1, no step, no position change.
- Mode gating of valid transitions:
  - X4: all transitions count.
  - X2: only transitions where A changed count.
  - X1: only the rising edge of A counts in fwd, and only the falling edge of A counts in reverse. This gives one count per cycle and is symmetric.
- Counted edge (registered, 1-cycle pulse): o_step=1 and o_dir = raw_dir ^ i_polarity. o_pos += 1 if o_dir, else -= 1. The counter wraps modulo 2^POS_W with no saturation.
- Latency: a clean input edge held stable produces its o_step exactly SYNC_STAGES+FILT_LEN+1 cycles after the first i_clk edge that samples it.
- Pulses narrower than FILT_LEN cycles at the synchroniser output are discarded entirely.
- i_clear: o_pos<=0 next cycle. If a counted edge occurs in the same cycle, clear wins and o_pos=0, but o_step/o_dir still pulse.
- o_err:
  - Sticky until i_err_clr.
  - If an illegal transition and i_err_clr occur in the same cycle, set wins.
  - Decoding continues after an error; prev_ab still updates.
- i_mode is not per-channel and may change at any time. It takes effect on the next decoded transition; prev_ab state is unaffected.
- Channels are fully independent; simultaneous events on different channels never interact.

Decomposition:
- Package enc_pkg: enc_mode_t enum (ENC_X1, ENC_X2, ENC_X4) and localparam FWD/REV transition lookup constants.
- Sub-module enc_input_filter: one bit of synchroniser plus filter, with parameters SYNC_STAGES and FILT_LEN. Instantiate 2*N_CH times.
- Decode FSM and counter are written inline in a generate loop over channels.

Test Plan:
- Reset with A=B=1 held, release, wait 10 cycles -> o_err=0, o_step never pulses, o_pos=0.
- X4, ch0 driven through 00->10->11->01->00 twice, 20 cycles per state -> 8 o_step pulses with o_dir=1, o_pos=8, each pulse exactly 6 cycles (2+3+1) after the input edge. Reverse sequence -> o_pos back to 0.
- Same 8 fwd transitions in X2 -> o_pos=4; in X1 -> o_pos=2; with i_polarity=1 in X4 -> o_pos=-8 (0xFFF8).
- 2-cycle glitch on A -> no o_step, o_pos unchanged. AB jumping 00->11 (both held 10 cycles) -> o_err=1, no step. Pulse i_err_clr -> o_err=0.
- POS_W=16, preload to 0x7FFF by stepping, then 1 fwd step -> o_pos=0x8000. From 0, 1 reverse step -> 0xFFFF. i_clear coincident with a step -> o_pos=0 and o_step=1.
- N_CH=2, opposite directions simultaneously on ch0/ch1 -> independent counts of +4/-4. Assert i_rst mid-sequence -> all outputs 0 immediately, and the channel re-enters INIT without an error.
